// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: parity mode constants, the
// receive FSM state encoding, oversample tick indices and small helper
// functions for the baud divisor, the 3-sample majority vote and parity.
// No ports; imported by uart_rx_stream.
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam int unsigned OVERSAMPLE  = 16;

  // Oversample tick indices inside one bit period. Ticks 7..9 straddle the
  // bit centre; the decision is made on tick 9 once all three are known.
  localparam logic [3:0] TICK_VOTE_A   = 4'd7;
  localparam logic [3:0] TICK_VOTE_B   = 4'd8;
  localparam logic [3:0] TICK_VOTE_C   = 4'd9;
  localparam logic [3:0] TICK_BIT_LAST = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned calcDivisor(input int unsigned clkHz,
                                              input int unsigned baud);
    longint unsigned den;
    den = 64'(baud) * 64'(OVERSAMPLE);
    return 32'((64'(clkHz) + den / 2) / den);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Expected parity bit for the given mode. Unused upper data bits must be
  // zero so they do not disturb the XOR.
  function automatic logic parityBit(input logic [8:0] data, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with registered first-word fall-through output.
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_wrEn/i_wrData  write request and word
//   o_wrOk           write accepted this cycle (not full, or popping now)
//   i_rdEn           consumer ready; a pop happens when i_rdEn && o_rdValid
//   o_rdData         oldest word, stable while o_rdValid && !i_rdEn
//   o_rdValid        FIFO holds at least one word (registered)
//   o_level          number of stored words
// DEPTH must be a power of two so the pointers wrap for free.
// ----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wrEn,
  input  logic [WIDTH-1:0]         i_wrData,
  output logic                     o_wrOk,
  input  logic                     i_rdEn,
  output logic [WIDTH-1:0]         o_rdData,
  output logic                     o_rdValid,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_levelNext;
  logic             r_valid;
  logic             w_full;
  logic             w_wrFire;
  logic             w_rdFire;

  assign w_full   = (r_level == LW'(DEPTH));
  assign w_rdFire = i_rdEn & r_valid;
  // A full FIFO can still take a word when the head leaves in the same cycle;
  // the write then lands in the slot being vacated.
  assign w_wrFire = i_wrEn & (~w_full | w_rdFire);

  always_comb begin
    w_levelNext = r_level;
    case ({w_wrFire, w_rdFire})
      2'b10:   w_levelNext = r_level + LW'(1);
      2'b01:   w_levelNext = r_level - LW'(1);
      default: w_levelNext = r_level;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wrFire) begin
      r_mem[r_wrPtr] <= i_wrData;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_wrFire) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_rdFire) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_level <= w_levelNext;
      r_valid <= (w_levelNext != '0);
    end
  end

  assign o_wrOk    = w_wrFire;
  assign o_rdData  = r_mem[r_rdPtr];
  assign o_rdValid = r_valid;
  assign o_level   = r_level;

endmodule

// File: rtl/uart_rx_stream.sv
// ----------------------------------------------------------------------------
// uart_rx_stream
// UART receiver with 16x oversampling, majority-vote bit decisions, optional
// parity, 1 or 2 stop bits, and a valid/ready output stream buffered by a FIFO.
//   sysclk        system clock (rising edge)
//   resetn        asynchronous active-low reset
//   uart_txd_in   asynchronous serial line, idles high
//   m_data        oldest received word
//   m_perr        parity error flag stored with m_data
//   m_ferr        framing error flag stored with m_data
//   m_valid       m_data/m_perr/m_ferr hold a word
//   m_ready       consumer accepts the word (pop on m_valid && m_ready)
//   fifo_level    number of stored words
//   overrun       sticky: a word was dropped because the FIFO was full
//   err_clr       pulse that clears overrun
// DATA_BITS 5..9, PARITY 0 none / 1 odd / 2 even, STOP_BITS 1 or 2,
// FIFO_DEPTH a power of two >= 2.
// ----------------------------------------------------------------------------
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = PARITY_NONE,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                         sysclk,
  input  logic                         resetn,
  input  logic                         uart_txd_in,
  output logic [DATA_BITS-1:0]         m_data,
  output logic                         m_perr,
  output logic                         m_ferr,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overrun,
  input  logic                         err_clr
);

  localparam int unsigned DIVISOR      = calcDivisor(CLK_FREQ_HZ, BAUD);
  localparam int unsigned DIV_W        = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned WORD_W       = DATA_BITS + 2;
  localparam logic [3:0]  BITCNT_LAST  = 4'(DATA_BITS - 1);
  localparam logic        STOPCNT_LAST = 1'(STOP_BITS - 1);

  // Line synchroniser and edge detector
  logic r_syncMeta;
  logic r_syncOut;
  logic r_rxdPrev;
  logic w_rxd;
  logic w_fall;

  // Start-up guard: the synchroniser powers up high, so its output is not a
  // trustworthy picture of the line until it has been refilled.
  logic [1:0] r_settle;
  logic       w_armed;

  // Oversample timing
  logic [DIV_W-1:0] r_divCnt;
  logic [3:0]       r_tickCnt;
  logic             w_tick;
  logic             w_voteNow;
  logic             w_bitEnd;
  logic [1:0]       r_samp;
  logic             w_vote;

  // Receive FSM and frame datapath
  rx_state_t            r_state;
  rx_state_t            w_stateNext;
  logic                 w_restart;
  logic                 w_shiftBit;
  logic                 w_dataBitDone;
  logic                 w_capParity;
  logic                 w_stopVote;
  logic                 w_stopBitDone;
  logic                 w_push;
  logic [DATA_BITS-1:0] r_shift;
  logic [3:0]           r_bitCnt;
  logic                 r_stopCnt;
  logic                 r_parBit;
  logic                 r_ferr;
  logic                 w_frameErr;
  logic                 w_perr;
  logic [WORD_W-1:0]    w_pushWord;

  // FIFO side
  logic              w_pushOk;
  logic [WORD_W-1:0] w_fifoOut;
  logic              r_overrun;

  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      r_syncMeta <= 1'b1;
      r_syncOut  <= 1'b1;
      r_rxdPrev  <= 1'b1;
      r_settle   <= 2'b00;
    end else begin
      r_syncMeta <= uart_txd_in;
      r_syncOut  <= r_syncMeta;
      r_rxdPrev  <= r_syncOut;
      r_settle   <= {r_settle[0], 1'b1};
    end
  end

  assign w_rxd   = r_syncOut;
  assign w_fall  = r_rxdPrev & ~w_rxd;
  assign w_armed = r_settle[1];

  // The tick phase is realigned to every accepted start edge so tick 8 lands
  // near the middle of each bit regardless of where the divider was.
  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      r_divCnt  <= '0;
      r_tickCnt <= '0;
    end else if (w_restart) begin
      r_divCnt  <= '0;
      r_tickCnt <= '0;
    end else if (w_tick) begin
      r_divCnt  <= '0;
      r_tickCnt <= r_tickCnt + 4'd1;
    end else begin
      r_divCnt  <= r_divCnt + DIV_W'(1);
    end
  end

  assign w_tick    = (r_divCnt == DIV_W'(DIVISOR - 1));
  assign w_voteNow = w_tick && (r_tickCnt == TICK_VOTE_C);
  assign w_bitEnd  = w_tick && (r_tickCnt == TICK_BIT_LAST);

  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      r_samp <= 2'b11;
    end else if (w_tick) begin
      if (r_tickCnt == TICK_VOTE_A) begin
        r_samp[0] <= w_rxd;
      end
      if (r_tickCnt == TICK_VOTE_B) begin
        r_samp[1] <= w_rxd;
      end
    end
  end

  assign w_vote = majority3(r_samp[0], r_samp[1], w_rxd);

  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // The word is pushed on the vote of the last stop bit rather than at the
  // end of the bit, which also frees the FSM to catch a back-to-back start.
  always_comb begin
    w_stateNext   = r_state;
    w_restart     = 1'b0;
    w_shiftBit    = 1'b0;
    w_dataBitDone = 1'b0;
    w_capParity   = 1'b0;
    w_stopVote    = 1'b0;
    w_stopBitDone = 1'b0;
    w_push        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_armed) begin
          w_stateNext = ST_WAIT_IDLE;
        end else if (w_fall) begin
          w_stateNext = ST_START;
          w_restart   = 1'b1;
        end
      end
      ST_START: begin
        if (w_voteNow && w_vote) begin
          w_stateNext = ST_IDLE;
        end else if (w_bitEnd) begin
          w_stateNext = ST_DATA;
        end
      end
      ST_DATA: begin
        w_shiftBit = w_voteNow;
        if (w_bitEnd) begin
          w_dataBitDone = 1'b1;
          if (r_bitCnt == BITCNT_LAST) begin
            w_stateNext = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        w_capParity = w_voteNow;
        if (w_bitEnd) begin
          w_stateNext = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_voteNow) begin
          w_stopVote = 1'b1;
          if (r_stopCnt == STOPCNT_LAST) begin
            w_push      = 1'b1;
            w_stateNext = w_frameErr ? ST_WAIT_IDLE : ST_IDLE;
          end
        end else if (w_bitEnd) begin
          w_stopBitDone = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_armed && w_rxd) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_WAIT_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      r_shift   <= '0;
      r_bitCnt  <= '0;
      r_stopCnt <= 1'b0;
      r_parBit  <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      if (w_restart) begin
        r_bitCnt  <= '0;
        r_stopCnt <= 1'b0;
        r_ferr    <= 1'b0;
      end
      if (w_shiftBit) begin
        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
      end
      if (w_dataBitDone) begin
        r_bitCnt <= r_bitCnt + 4'd1;
      end
      if (w_capParity) begin
        r_parBit <= w_vote;
      end
      if (w_stopVote) begin
        r_ferr <= r_ferr | ~w_vote;
      end
      if (w_stopBitDone) begin
        r_stopCnt <= r_stopCnt + 1'b1;
      end
    end
  end

  // Includes the stop vote being taken this very cycle.
  assign w_frameErr = r_ferr | ~w_vote;
  assign w_perr     = (PARITY != PARITY_NONE) &&
                      (r_parBit != parityBit(9'(r_shift), PARITY));
  assign w_pushWord = {w_perr, w_frameErr, r_shift};

  uart_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (sysclk),
    .i_rst_n   (resetn),
    .i_wrEn    (w_push),
    .i_wrData  (w_pushWord),
    .o_wrOk    (w_pushOk),
    .i_rdEn    (m_ready),
    .o_rdData  (w_fifoOut),
    .o_rdValid (m_valid),
    .o_level   (fifo_level)
  );

  // A fresh drop wins over a simultaneous clear.
  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= (r_overrun & ~err_clr) | (w_push & ~w_pushOk);
    end
  end

  assign overrun = r_overrun;
  assign m_perr  = w_fifoOut[WORD_W-1];
  assign m_ferr  = w_fifoOut[WORD_W-2];
  assign m_data  = w_fifoOut[DATA_BITS-1:0];

endmodule

// File: doc/uart_rx_stream.md
UART_RX_STREAM -- requirements
Module: uart_rx_stream

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 12_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, minimum 2.
REQ-007 sysclk  input  1  single system clock; all logic rising-edge.
REQ-008 resetn  input  1  reset, asynchronous assert, active-low.
REQ-009 uart_txd_in  input  1  asynchronous serial line from host; idles high.
REQ-010 m_data  output  DATA_BITS  oldest received word.
REQ-011 m_perr  output  1  parity error flag stored with m_data.
REQ-012 m_ferr  output  1  framing error flag stored with m_data.
REQ-013 m_valid  output  1  m_data, m_perr and m_ferr hold a word.
REQ-014 m_ready  input  1  consumer accepts the word.
REQ-015 fifo_level  output  $clog2(FIFO_DEPTH)+1  number of stored words.
REQ-016 overrun  output  1  sticky flag: a word was dropped because the FIFO was full.
REQ-017 err_clr  input  1  single-cycle pulse that clears overrun.

Function
REQ-018 uart_txd_in SHALL pass through a two-flop synchroniser before any use.
REQ-019 The oversample tick SHALL be 16x BAUD, with divisor round(CLK_FREQ_HZ/(16*BAUD)); the default parameters give a divisor of 78.
REQ-020 The receive FSM SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-021 IDLE -> START on a synchronised high-to-low transition; the tick phase counter restarts at this point.
REQ-022 Each bit SHALL be decided by a majority vote of oversample ticks 7, 8 and 9 of that bit.
REQ-023 If the START-bit vote is high (glitch), the FSM SHALL return to IDLE and push no word.
REQ-024 DATA SHALL shift in DATA_BITS bits, LSB first.
REQ-025 PARITY SHALL be entered only when PARITY != 0; m_perr = (received parity != computed parity).
REQ-026 STOP SHALL check STOP_BITS stop bits; if any stop vote is low, the word's ferr = 1.
REQ-027 The word, with its perr and ferr flags, SHALL be pushed at the vote of the last stop bit, so a frame is never dropped silently.
REQ-028 After a framing error the FSM SHALL go to WAIT_IDLE and stay there until the line reads high, so a break condition yields exactly one word.
REQ-029 The push SHALL be accepted if the FIFO is not full, or if a pop occurs in the same cycle; otherwise the word is dropped and overrun is set.
REQ-030 The pop condition is m_valid && m_ready; m_data, m_perr and m_ferr SHALL stay stable while m_valid=1 and m_ready=0.
REQ-031 m_valid SHALL rise on the cycle after a push into an empty FIFO; first-word fall-through, registered.
REQ-032 fifo_level SHALL be +1 on a push only, -1 on a pop only, unchanged on simultaneous push and pop.
REQ-033 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 If err_clr and a new overrun occur in the same cycle, overrun SHALL remain set.

Reset
REQ-035 While resetn=0: FSM = IDLE, FIFO empty, m_valid=0, m_data=0, m_perr=0, m_ferr=0, fifo_level=0, overrun=0, synchroniser flops =1.
REQ-036 Reset during a frame SHALL abort that frame; no partial word is ever pushed.
REQ-037 After reset release, the FSM SHALL start in WAIT_IDLE, so a low line mid-frame is not treated as a start bit.

Structure
REQ-038 Package uart_pkg SHALL hold the parity mode constants, the FSM state enum and the divisor/majority helper functions.
REQ-039 The FIFO SHALL be the sub-module uart_sync_fifo, parametrised by width (DATA_BITS+2) and depth.

Verification
REQ-040 Default parameters, send 0xA5 8N1 at 9600 baud -> exactly one word: m_data=0xA5, m_perr=0, m_ferr=0, m_valid high within 11 bit times of the start edge.
REQ-041 PARITY=2, send 0x3C with the parity bit forced to 1 -> m_data=0x3C, m_perr=1; then a correct 0x3C -> m_perr=0.
REQ-042 Send 0x55 with the stop bit held low for 3 bit times -> one word, m_data=0x55, m_ferr=1, and no further word until the line returns high.
REQ-043 Send a 2-tick low glitch, then a valid 0x81 -> exactly one word, 0x81.
REQ-044 With m_ready=0, send 17 words 0x00..0x10 -> fifo_level=16, overrun=1; then m_ready=1 -> 0x00..0x0F read in order; err_clr -> overrun=0.
REQ-045 Assert resetn=0 at data bit 4 of a frame, release, then send 0x7E -> only 0x7E is received.
